// File: rtl/vga_pkg.sv
// Shared VGA constants and types for the sprite pixel-source path.
package vga_pkg;

  localparam int H_ACTIVE   = 640;
  localparam int V_ACTIVE   = 480;
  localparam int DATA_WIDTH = 24;

  localparam logic [23:0] TRANSPARENT = 24'h000000;

  typedef logic [9:0] coord_t;

  // Position that parks the sprite beyond any visible raster coordinate.
  localparam coord_t POS_OFFSCREEN = 10'h3FF;

endpackage

// File: rtl/sprite_fetch_if.sv
// Sprite position request channel: valid/ready handshake carrying the top-left corner.
interface sprite_fetch_if;
  import vga_pkg::*;

  coord_t pos_x;
  coord_t pos_y;
  logic   pos_valid;
  logic   pos_ready;

  modport master (output pos_x, output pos_y, output pos_valid, input pos_ready);
  modport slave  (input pos_x, input pos_y, input pos_valid, output pos_ready);

endinterface

// File: rtl/sprite_fetch_pos_shadow.sv
// Position shadow register with once-per-frame commit into the active sprite position.
module sprite_pos_shadow
  import vga_pkg::*;
#(
  parameter int V_COMMIT = 480
) (
  input  logic           clk,
  input  logic           reset,
  input  coord_t         hcount,
  input  coord_t         vcount,
  sprite_fetch_if.slave  pos,
  output coord_t         act_x,
  output coord_t         act_y,
  output logic           frame_start
);

  logic   cond;
  logic   cond_q;
  logic   commit;
  logic   xfer;
  logic   shadow_full;
  logic   full_nxt;
  coord_t sh_x;
  coord_t sh_y;

  // Edge detect so a held hcount==0 on the commit line fires only once.
  assign cond        = (hcount == 10'd0) && (vcount == 10'(V_COMMIT));
  assign commit      = cond && !cond_q && !reset;
  assign xfer        = pos.pos_valid && pos.pos_ready;
  assign frame_start = commit;

  always_comb begin
    full_nxt = shadow_full;
    if (commit && shadow_full) full_nxt = 1'b0;
    if (xfer)                  full_nxt = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cond_q        <= 1'b0;
      shadow_full   <= 1'b0;
      pos.pos_ready <= 1'b0;
      act_x         <= POS_OFFSCREEN;
      act_y         <= POS_OFFSCREEN;
    end else begin
      cond_q        <= cond;
      shadow_full   <= full_nxt;
      pos.pos_ready <= !full_nxt;
      if (commit && shadow_full) begin
        act_x <= sh_x;
        act_y <= sh_y;
      end
    end
  end

  // Shadow contents are qualified by shadow_full, so they need no reset.
  always_ff @(posedge clk) begin
    if (xfer) begin
      sh_x <= pos.pos_x;
      sh_y <= pos.pos_y;
    end
  end

endmodule

// File: rtl/sprite_fetch.sv
// Sprite pixel source: hit test, ROM addressing and a 2-cycle aligned pixel pipeline.
module sprite_fetch
  import vga_pkg::*;
#(
  parameter int DATA_WIDTH = 24,
  parameter int SPR_W      = 16,
  parameter int SPR_H      = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int V_COMMIT   = 480
) (
  input  logic                  clk,
  input  logic                  reset,
  input  coord_t                hcount,
  input  coord_t                vcount,
  input  logic                  bright,
  sprite_fetch_if.slave         pos,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output logic [DATA_WIDTH-1:0] pixel,
  output logic                  pix_en,
  output logic                  bright_d,
  output coord_t                hcount_d,
  output coord_t                vcount_d,
  output logic                  frame_start
);

  localparam int XB = $clog2(SPR_W);
  localparam int YB = $clog2(SPR_H);

  coord_t act_x;
  coord_t act_y;

  sprite_pos_shadow #(.V_COMMIT(V_COMMIT)) u_shadow (
    .clk         (clk),
    .reset       (reset),
    .hcount      (hcount),
    .vcount      (vcount),
    .pos         (pos),
    .act_x       (act_x),
    .act_y       (act_y),
    .frame_start (frame_start)
  );

  // True when coordinate c lies in [org, org+len); no wrap past the raster edge.
  function automatic logic span_hit(input coord_t c, input coord_t org, input int len);
    logic [10:0] d;
    d = {1'b0, c} - {1'b0, org};
    return (c >= org) && (d < 11'(len));
  endfunction

  logic [10:0]           dx_p0;
  logic [10:0]           dy_p0;
  logic                  inside_p0;
  logic [ADDR_WIDTH-1:0] addr_p0;

  assign dx_p0     = {1'b0, hcount} - {1'b0, act_x};
  assign dy_p0     = {1'b0, vcount} - {1'b0, act_y};
  assign inside_p0 = span_hit(hcount, act_x, SPR_W) && span_hit(vcount, act_y, SPR_H);
  assign addr_p0   = ADDR_WIDTH'({dy_p0[YB-1:0], dx_p0[XB-1:0]});

  logic   inside_p1;
  logic   bright_p1;
  coord_t hcount_p1;
  coord_t vcount_p1;

  // Stage 1: ROM address plus raster context.
  always_ff @(posedge clk) begin
    if (reset) begin
      rom_addr  <= '0;
      inside_p1 <= 1'b0;
      bright_p1 <= 1'b0;
      hcount_p1 <= '0;
      vcount_p1 <= '0;
    end else begin
      rom_addr  <= inside_p0 ? addr_p0 : '0;
      inside_p1 <= inside_p0;
      bright_p1 <= bright;
      hcount_p1 <= hcount;
      vcount_p1 <= vcount;
    end
  end

  // Stage 2: ROM word joins the delayed raster context.
  always_ff @(posedge clk) begin
    if (reset) begin
      pixel    <= '0;
      pix_en   <= 1'b0;
      bright_d <= 1'b0;
      hcount_d <= '0;
      vcount_d <= '0;
    end else begin
      pixel    <= inside_p1 ? rom_data : DATA_WIDTH'(TRANSPARENT);
      pix_en   <= inside_p1 && bright_p1;
      bright_d <= bright_p1;
      hcount_d <= hcount_p1;
      vcount_d <= vcount_p1;
    end
  end

endmodule
